// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : 5-stage pipeline hazard controller: forwarding, load-use and
//           mul/div interlock, stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             dmd,
  input  logic             dmdrd,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  output logic             wpcir,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] C_MD_LOAD = 4'(MD_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_md_done;
  logic             w_md_done_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;
  logic             w_mh;
  logic             w_stall;

  // EX-stage loads have no data yet, so only MEM can supply a load result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_rn,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] m_rn,
    input logic       m_wreg,
    input logic       m_m2reg
  );
    if (e_wreg && (e_rn != 5'd0) && (e_rn == src) && !e_m2reg)
      return 2'b01;
    else if (m_wreg && (m_rn != 5'd0) && (m_rn == src))
      return m_m2reg ? 2'b11 : 2'b10;
    else
      return 2'b00;
  endfunction

  assign fwda = fwd_sel(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
  assign fwdb = fwd_sel(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);

  assign w_lu = ewreg & em2reg & (ern != 5'd0) &
                ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
  assign md_busy   = (r_state == S_BUSY);
  assign w_mh      = md_busy & (dmd | dmdrd);
  assign w_stall   = w_lu | w_mh;
  assign wpcir     = ~w_stall;
  assign bubble    = w_stall;
  assign md_start  = dmd & ~w_stall & ~md_busy;
  assign md_done   = r_md_done;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_md_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (md_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = C_MD_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt   = S_IDLE;
          w_md_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_md_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_done <= w_md_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Self-checking bench for pipe_hazard_ctrl (vector table + sequences).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       dmd;
    logic       dmdrd;
    logic [4:0] ern;
    logic       ewreg;
    logic       em2reg;
    logic [4:0] mrn;
    logic       mwreg;
    logic       mm2reg;
  } in_t;

  typedef struct packed {
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       wpcir;
    logic       bubble;
    logic       md_start;
    logic       md_busy;
    logic       md_done;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  typedef struct packed {
    exp_t        e;
    logic [15:0] cnt;
  } sb_t;

  logic        clk = 1'b0;
  logic        clrn;
  in_t         din;
  logic        wpcir, bubble, md_start, md_busy, md_done;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;
  logic        s_wpcir, s_bubble, s_md_start, s_md_busy, s_md_done;
  logic [1:0]  s_fwda, s_fwdb;
  logic [3:0]  s_stall_cnt;

  int          n_tot = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;
  sb_t         sb_q[$];
  vec_t        tbl[10];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .clrn(clrn), .rs(din.rs), .rt(din.rt), .use_rs(din.use_rs),
    .use_rt(din.use_rt), .dmd(din.dmd), .dmdrd(din.dmdrd), .ern(din.ern),
    .ewreg(din.ewreg), .em2reg(din.em2reg), .mrn(din.mrn), .mwreg(din.mwreg),
    .mm2reg(din.mm2reg), .wpcir(wpcir), .bubble(bubble), .fwda(fwda),
    .fwdb(fwdb), .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .clrn(clrn), .rs(din.rs), .rt(din.rt), .use_rs(din.use_rs),
    .use_rt(din.use_rt), .dmd(din.dmd), .dmdrd(din.dmdrd), .ern(din.ern),
    .ewreg(din.ewreg), .em2reg(din.em2reg), .mrn(din.mrn), .mwreg(din.mwreg),
    .mm2reg(din.mm2reg), .wpcir(s_wpcir), .bubble(s_bubble), .fwda(s_fwda),
    .fwdb(s_fwdb), .md_start(s_md_start), .md_busy(s_md_busy),
    .md_done(s_md_done), .stall_cnt(s_stall_cnt)
  );

  function automatic in_t mi(int rs_v, int rt_v, bit urs, bit urt, bit dmd_v,
                             bit dmdrd_v, int ern_v, bit ew, bit em,
                             int mrn_v, bit mw, bit mm);
    in_t r;
    r.rs = 5'(rs_v);     r.rt = 5'(rt_v);
    r.use_rs = urs;      r.use_rt = urt;
    r.dmd = dmd_v;       r.dmdrd = dmdrd_v;
    r.ern = 5'(ern_v);   r.ewreg = ew;    r.em2reg = em;
    r.mrn = 5'(mrn_v);   r.mwreg = mw;    r.mm2reg = mm;
    return r;
  endfunction

  function automatic exp_t me(int fa, int fb, bit wp, bit bb, bit st,
                              bit busy, bit done);
    exp_t r;
    r.fwda = 2'(fa);  r.fwdb = 2'(fb);
    r.wpcir = wp;     r.bubble = bb;
    r.md_start = st;  r.md_busy = busy;  r.md_done = done;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, record expectation, compare mid-cycle.
  task automatic step(string tag, in_t i, exp_t e);
    sb_t s;
    din = i;
    sb_q.push_back('{e: e, cnt: exp_cnt});
    @(negedge clk);
    s = sb_q.pop_front();
    chk({tag, ".fwda"},      32'(fwda),      32'(s.e.fwda));
    chk({tag, ".fwdb"},      32'(fwdb),      32'(s.e.fwdb));
    chk({tag, ".wpcir"},     32'(wpcir),     32'(s.e.wpcir));
    chk({tag, ".bubble"},    32'(bubble),    32'(s.e.bubble));
    chk({tag, ".md_start"},  32'(md_start),  32'(s.e.md_start));
    chk({tag, ".md_busy"},   32'(md_busy),   32'(s.e.md_busy));
    chk({tag, ".md_done"},   32'(md_done),   32'(s.e.md_done));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(s.cnt));
    if (!e.wpcir) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    din  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.md_busy",   32'(md_busy),   32'd0);
    chk("rst.md_done",   32'(md_done),   32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst.wpcir",     32'(wpcir),     32'd1);
    clrn    = 1'b0;
    exp_cnt = 16'd0;
  endtask

  initial begin
    tbl[0] = '{i: mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e: me(0, 0, 1, 0, 0, 0, 0)};
    tbl[1] = '{i: mi(5, 0, 1, 0, 0, 0, 5, 1, 0, 5, 1, 0), e: me(1, 0, 1, 0, 0, 0, 0)};
    tbl[2] = '{i: mi(5, 0, 1, 0, 0, 0, 5, 0, 0, 5, 1, 1), e: me(3, 0, 1, 0, 0, 0, 0)};
    tbl[3] = '{i: mi(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0), e: me(0, 0, 1, 0, 0, 0, 0)};
    tbl[4] = '{i: mi(5, 0, 0, 0, 0, 0, 5, 1, 1, 5, 1, 0), e: me(2, 0, 1, 0, 0, 0, 0)};
    tbl[5] = '{i: mi(3, 7, 1, 1, 0, 0, 7, 1, 1, 7, 1, 1), e: me(0, 3, 0, 1, 0, 0, 0)};
    tbl[6] = '{i: mi(3, 7, 1, 1, 0, 0, 7, 0, 1, 7, 1, 1), e: me(0, 3, 1, 0, 0, 0, 0)};
    tbl[7] = '{i: mi(9, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0), e: me(0, 0, 1, 0, 0, 0, 0)};
    tbl[8] = '{i: mi(12, 12, 1, 1, 0, 0, 12, 1, 0, 12, 1, 0), e: me(1, 1, 1, 0, 0, 0, 0)};
    tbl[9] = '{i: mi(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0), e: me(0, 0, 1, 0, 0, 0, 0)};

    exp_cnt = 16'd0;
    do_reset();

    for (int k = 0; k < 10; k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Mul/div issue, then an mfhi held for the whole busy window.
    do_reset();
    step("md0", mi(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++)
      step($sformatf("md%0d", k), mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
           me(0, 0, 0, 1, 0, 1, 0));
    step("md5", mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 0, 1));
    chk("md.stall_total", 32'(stall_cnt), 32'd4);
    step("md6", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 0, 0));

    // Load-use blocks the issue; it fires once the load clears.
    step("sim0", mi(7, 0, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0), me(0, 0, 0, 1, 0, 0, 0));
    step("sim1", mi(7, 0, 1, 0, 1, 0, 7, 0, 1, 0, 0, 0), me(0, 0, 1, 0, 1, 0, 0));
    step("sim2", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 1, 0));
    step("sim3", mi(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 0, 1, 0, 1, 0));
    step("sim4", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 1, 0));
    step("sim5", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 1, 0));
    step("sim6", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 0, 1));
    step("sim7", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 0, 0, 0));

    // Asynchronous reset while the counter holds 2.
    do_reset();
    step("rb0", mi(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 1, 0, 1, 0, 0));
    step("rb1", mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), me(0, 0, 0, 1, 0, 1, 0));
    din = mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rb2.stall_pre", 32'(stall_cnt), 32'd1);
    #1 clrn = 1'b1;
    #1;
    chk("rb.md_busy",   32'(md_busy),   32'd0);
    chk("rb.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rb.wpcir",     32'(wpcir),     32'd1);
    @(posedge clk);
    #1 clrn = 1'b0;
    exp_cnt = 16'd0;
    for (int k = 0; k < 6; k++)
      step($sformatf("rb_post%0d", k), mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           me(0, 0, 1, 0, 0, 0, 0));

    // Twenty held load-use cycles: narrow counter pins at 15.
    do_reset();
    for (int k = 0; k < 20; k++)
      step($sformatf("sat%0d", k), mi(0, 4, 0, 1, 0, 0, 4, 1, 1, 0, 0, 0),
           me(0, 0, 0, 1, 0, 0, 0));
    chk("sat.narrow20", 32'(s_stall_cnt), 32'd15);
    step("sat20", mi(0, 4, 0, 1, 0, 0, 4, 1, 1, 0, 0, 0), me(0, 0, 0, 1, 0, 0, 0));
    chk("sat.narrow21", 32'(s_stall_cnt), 32'd15);
    chk("sat.wide21",   32'(stall_cnt),   32'd21);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline. It drives the ID/EX register from the decode stage and gates the PC and IF/ID registers. It computes forwarding selects, detects load-use hazards, and tracks a multi-cycle multiply/divide unit with an internal FSM. It stalls decode and inserts bubbles into ID/EX until hazards clear, and keeps a stall-cycle performance counter.

Parameters:
MD_LAT, 4, cycles the mul/div unit is busy after issue (legal range 2..15)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous reset, active-high
rs  in  5  decode-stage source register A
rt  in  5  decode-stage source register B
use_rs  in  1  decode instruction reads rs
use_rt  in  1  decode instruction reads rt
dmd  in  1  decode instruction issues a mul/div op
dmdrd  in  1  decode instruction reads the HI/LO result (mfhi/mflo)
ern  in  5  EX-stage destination register
ewreg  in  1  EX-stage writes register
em2reg  in  1  EX-stage is a load
mrn  in  5  MEM-stage destination register
mwreg  in  1  MEM-stage writes register
mm2reg  in  1  MEM-stage is a load
wpcir  out  1  write enable for PC and IF/ID (0 = hold)
bubble  out  1  1 = force dwreg/dwmem/djal to 0 into ID/EX
fwda  out  2  operand A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
fwdb  out  2  operand B select, same encoding
md_start  out  1  one-cycle pulse to launch the mul/div unit
md_busy  out  1  FSM in BUSY
md_done  out  1  registered one-cycle pulse when the result is ready
stall_cnt  out  CNT_W  count of cycles with wpcir=0, saturating

Behaviour:
- Reset (clrn=1, async): state IDLE, counter 0, md_done 0, stall_cnt 0. Combinational outputs follow from IDLE: md_busy=0, md_start=0, wpcir=1 and bubble=0 unless a load-use hazard is present.
- Forwarding (combinational), evaluated for rs→fwda and rt→fwdb:
  - EX match takes priority: ewreg & ern!=0 & ern==src & !em2reg → 01.
  - Else MEM match: mwreg & mrn!=0 & mrn==src → 10 if !mm2reg, 11 if mm2reg.
  - Else 00. Register 0 never forwards.
- Load-use hazard: lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- MD hazard: mh = md_busy & (dmd | dmdrd).
- stall = lu | mh. While stall: wpcir=0, bubble=1. Otherwise wpcir=1, bubble=0.
- md_start = dmd & !stall & !md_busy. It is combinational and fires in the same cycle the instruction leaves ID.
- FSM, two states:
  - IDLE: on md_start go to BUSY and load the counter with MD_LAT-1.
  - BUSY: decrement the counter each cycle. When the counter is 0, return to IDLE and register md_done=1 for exactly the next cycle.
  - Total busy cycles = MD_LAT.
- An instruction reading HI/LO or issuing mul/div during BUSY is held in ID. It proceeds in the first IDLE cycle, which is the cycle md_done=1.
- Simultaneous lu and md issue: the issue is blocked (md_start=0) and the FSM stays IDLE.
- stall_cnt increments on each clock edge where stall=1 and saturates at all-ones.
- Reset mid-BUSY aborts the operation immediately: no md_done pulse.
- Forwarding selects are independent of stall. A bubbled cycle still drives valid selects.

Test Plan:
- Reset → clrn=1 mid-BUSY with counter 2 → state IDLE, md_busy=0, md_done stays 0, stall_cnt=0, wpcir=1.
- Forwarding priority → ern=mrn=5, ewreg=mwreg=1, em2reg=0, rs=5, use_rs=1 → fwda=01. Then ewreg=0, mm2reg=1 → fwda=11. Then rs=0 → fwda=00.
- Load-use stall → ern=7, ewreg=em2reg=1, rt=7, use_rt=1 → wpcir=0, bubble=1 for one cycle, stall_cnt +1. Next cycle with ewreg=0 → wpcir=1.
- MD sequence, MD_LAT=4 → dmd=1 gives md_start pulse and md_busy=1 for 4 cycles. A dmdrd instruction issued during BUSY stalls 4 cycles, then proceeds in the cycle md_done=1. stall_cnt=4.
- Simultaneous hazards → dmd=1 with a load-use hazard present → md_start=0, FSM stays IDLE. After the hazard clears, md_start=1.
- Saturation → CNT_W=4, hold stall for 20 cycles → stall_cnt=15 and holds at 15.
